// File: rtl/ex_mem.sv
// EX -> MEM pipeline register with pass / bubble / hold behaviour from the stall vector.
// Define EX_MEM_HILO_EN to also carry the HI/LO write request and the madd/msub accumulation state.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
`ifdef EX_MEM_HILO_EN
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
`endif
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata
`ifdef EX_MEM_HILO_EN
    ,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
`endif
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {
        ACT_PASS   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } act_e;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } wb_req_t;

    act_e    act;
    wb_req_t wb_d, wb_q;

    // Only the EX and MEM stop bits matter at this boundary.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // EX running always passes, which also covers the unreachable EX-run/MEM-stop case.
    always_comb begin
        act = ACT_PASS;
        if (stall[3] == STOP)
            act = (stall[4] == STOP) ? ACT_HOLD : ACT_BUBBLE;
    end

    always_comb begin
        wb_d = wb_q;
        case (act)
            ACT_PASS:   wb_d = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata};
            ACT_BUBBLE: wb_d = '0;
            default:    wb_d = wb_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wb_q <= '0;
        else     wb_q <= wb_d;
    end

    assign mem_wd    = wb_q.wd;
    assign mem_wreg  = wb_q.wreg;
    assign mem_wdata = wb_q.wdata;

`ifdef EX_MEM_HILO_EN
    typedef struct packed {
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_req_t;

    typedef struct packed {
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } acc_t;

    hilo_req_t hl_d, hl_q;
    acc_t      acc_d, acc_q;

    // Accumulation state is only kept while EX is stalled; any pass starts it afresh.
    always_comb begin
        hl_d  = hl_q;
        acc_d = acc_q;
        case (act)
            ACT_PASS: begin
                hl_d  = '{whilo: ex_whilo, hi: ex_hi, lo: ex_lo};
                acc_d = '0;
            end
            ACT_BUBBLE: begin
                hl_d  = '0;
                acc_d = '{hilo: hilo_i, cnt: cnt_i};
            end
            default: begin
                hl_d  = hl_q;
                acc_d = acc_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hl_q  <= '0;
            acc_q <= '0;
        end else begin
            hl_q  <= hl_d;
            acc_q <= acc_d;
        end
    end

    assign mem_whilo = hl_q.whilo;
    assign mem_hi    = hl_q.hi;
    assign mem_lo    = hl_q.lo;
    assign hilo_o    = acc_q.hilo;
    assign cnt_o     = acc_q.cnt;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed cases from the test plan plus randomized
// stall/data traffic against a behavioural model (HI/LO fields checked when EX_MEM_HILO_EN is set).
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic        ex_whilo = 1'b0;
    logic [31:0] ex_hi = '0;
    logic [31:0] ex_lo = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
`ifdef EX_MEM_HILO_EN
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
`else
    logic unused_tb;
    assign unused_tb = ^{ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i};
`endif

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
`ifdef EX_MEM_HILO_EN
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
`endif
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata)
`ifdef EX_MEM_HILO_EN
        ,
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_wd = '0; e_wreg = 1'b0; e_wdata = '0;
        e_whilo = 1'b0; e_hi = '0; e_lo = '0; e_hilo = '0; e_cnt = '0;
    endtask

    // Behaviour at one rising edge, straight from the stall rules.
    task automatic model_edge();
        if (!stall[3]) begin
            e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
            e_whilo = ex_whilo; e_hi = ex_hi; e_lo = ex_lo;
            e_hilo = 64'd0; e_cnt = 2'd0;
        end else if (!stall[4]) begin
            e_wd = 5'd0; e_wreg = 1'b0; e_wdata = 32'd0;
            e_whilo = 1'b0; e_hi = 32'd0; e_lo = 32'd0;
            e_hilo = hilo_i; e_cnt = cnt_i;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".wd"},    64'(mem_wd),    64'(e_wd));
        chk({tag, ".wreg"},  64'(mem_wreg),  64'(e_wreg));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(e_wdata));
`ifdef EX_MEM_HILO_EN
        chk({tag, ".whilo"}, 64'(mem_whilo), 64'(e_whilo));
        chk({tag, ".hi"},    64'(mem_hi),    64'(e_hi));
        chk({tag, ".lo"},    64'(mem_lo),    64'(e_lo));
        chk({tag, ".hilo"},  hilo_o,         e_hilo);
        chk({tag, ".cnt"},   64'(cnt_o),     64'(e_cnt));
`endif
    endtask

    // Inputs are driven at the falling edge; outputs are sampled one falling edge later.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic drive(input logic [5:0] st, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                         input logic [31:0] lo, input logic [63:0] hl, input logic [1:0] cnt);
        stall = st; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_whilo = whilo; ex_hi = hi; ex_lo = lo; hilo_i = hl; cnt_i = cnt;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_clear();
        chk_all({tag, ".async"});
        step({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        drive(6'b000000, 5'd3, 1'b1, 32'h55, 1'b1, 32'h9, 32'h8, 64'h77, 2'b11);
        @(negedge clk);
        chk_all("reset");
        step("reset_edge");
        rst = 1'b0;

        // Reset mid-run
        drive(6'b000000, 5'd9, 1'b1, 32'hDEADBEEF, 1'b1, 32'h3, 32'h4, 64'h0, 2'b00);
        step("pre_rst");
        async_reset("rst_mid");

        // Pass
        drive(6'b000000, 5'd7, 1'b1, 32'h0000FF00, 1'b1, 32'h1, 32'h2, 64'hFFFF, 2'b10);
        step("pass");
        chk("pass.wdata_lit", 64'(mem_wdata), 64'h0000FF00);

        // Bubble
        drive(6'b001111, 5'd7, 1'b1, 32'h0000FF00, 1'b1, 32'h1, 32'h2,
              64'h0000_0001_0000_0002, 2'b01);
        step("bubble");
        chk("bubble.wreg_lit", 64'(mem_wreg), 64'd0);

        // Hold
        drive(6'b000000, 5'd12, 1'b1, 32'h12345678, 1'b0, 32'h5, 32'h6, 64'h0, 2'b00);
        step("hold_load");
        for (int i = 0; i < 3; i++) begin
            drive(6'b011111, 5'(i), 1'b0, 32'hA5A5_0000 ^ 32'(i * 32'h1111), 1'b1,
                  32'(i), 32'(i + 1), 64'(i), 2'(i));
            step($sformatf("hold%0d", i));
            chk($sformatf("hold%0d.wdata_lit", i), 64'(mem_wdata), 64'h12345678);
        end

        // Accumulation sequence, then reset in the middle of one
        drive(6'b001111, 5'd1, 1'b1, 32'h1, 1'b1, 32'h1, 32'h1, 64'h1234_5678_9ABC_DEF0, 2'b01);
        step("acc_bubble");
        drive(6'b000000, 5'd2, 1'b1, 32'h7, 1'b1, 32'hA, 32'hB, 64'hCAFE, 2'b10);
        step("acc_pass");
        drive(6'b001111, 5'd1, 1'b1, 32'h1, 1'b1, 32'h1, 32'h1, 64'hFEED_0000_0000_BEEF, 2'b10);
        step("acc_bubble2");
        async_reset("rst_acc");

        // Unreachable combination behaves as pass
        drive(6'b010000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
        step("unreach");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [5:0] st;
            st = 6'($urandom);
            case ($urandom_range(0, 3))
                0: st[4:3] = 2'b00;
                1: st[4:3] = 2'b01;
                2: st[4:3] = 2'b11;
                default: st[4:3] = 2'b10;
            endcase
            drive(st, 5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                  {$urandom, $urandom}, 2'($urandom));
            step($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. It captures the execute result on every rising clock edge and honours the pipeline controller's stall vector: it passes the result, holds it, or inserts a bubble into MEM. It also carries the HI/LO write request and the multi-cycle accumulation state (partial product plus cycle count) that execute needs across its own stall cycles, for instructions such as madd/msub.

## Interface
Parameters:
- none; widths come from `defines.v` (`RegBus`=32, `RegAddrBus`=5, `DoubleRegBus`=64, `RstEnable`=1'b1, `Stop`=1'b1, `NoStop`=1'b0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  6  stall vector from ctrl; bit 3 = EX stopped, bit 4 = MEM stopped.
- ex_wd  input  5  destination register address from EX.
- ex_wreg  input  1  register write enable from EX.
- ex_wdata  input  32  write data from EX.
- ex_whilo  input  1  HI/LO write enable from EX.
- ex_hi  input  32  HI value from EX.
- ex_lo  input  32  LO value from EX.
- hilo_i  input  64  partial accumulation result from EX.
- cnt_i  input  2  accumulation cycle index from EX.
- mem_wd  output  5  registered destination address to MEM.
- mem_wreg  output  1  registered write enable to MEM.
- mem_wdata  output  32  registered write data to MEM.
- mem_whilo  output  1  registered HI/LO write enable to MEM.
- mem_hi  output  32  registered HI value to MEM.
- mem_lo  output  32  registered LO value to MEM.
- hilo_o  output  64  stored partial accumulation, returned to EX.
- cnt_o  output  2  stored cycle index, returned to EX.

## Operation
The action taken at each rising edge depends on `stall[3]` and `stall[4]`:
- **Pass** (`stall[3]`=NoStop): all `mem_*` outputs take their `ex_*` inputs; `hilo_o` clears to 0 and `cnt_o` clears to 2'b00.
- **Bubble** (`stall[3]`=Stop, `stall[4]`=NoStop):
  - `mem_wd`=0, `mem_wreg`=0, `mem_wdata`=0, `mem_whilo`=0, `mem_hi`=0, `mem_lo`=0.
  - `hilo_o` takes `hilo_i` and `cnt_o` takes `cnt_i`, so the accumulation state survives the EX stall.
- **Hold** (`stall[3]`=Stop, `stall[4]`=Stop): every output keeps its value.
- **Unreachable combination** (`stall[3]`=NoStop, `stall[4]`=Stop): the controller never produces it. The block treats it as Pass.

Other rules:
- No arithmetic is performed; all fields are stored at full width with no truncation.
- **Reset:** asserting `rst` clears every output to 0 immediately, independent of `clk`. This also applies in the middle of an accumulation sequence, and the partial result is discarded.
- **Reset release:** the first rising edge with `rst` low applies the normal rules.

## Timing
- Latency: exactly 1 cycle from `ex_*` to `mem_*` in Pass.
- Bubble cycles: MEM sees a zeroed, non-writing instruction.
- Accumulation feedback: `hilo_o` and `cnt_o` are valid 1 cycle after the Bubble edge and feed EX combinationally in the next cycle.
- Clocking: no combinational path from input to output; every output is a flop.
- Reset values: all outputs 0.

## Configuration
Controlled by the macro `EX_MEM_HILO_EN`:
- **Defined:** the HI/LO ports and the accumulation ports (`ex_whilo`, `ex_hi`, `ex_lo`, `hilo_i`, `cnt_i`, `mem_whilo`, `mem_hi`, `mem_lo`, `hilo_o`, `cnt_o`) exist and behave as specified above.
- **Undefined:**
  - Those ports and their flops are removed.
  - Only `mem_wd`, `mem_wreg` and `mem_wdata` are registered.
  - The stall and reset rules are unchanged for the remaining outputs.

## Test plan
- **Reset mid-run:** drive `ex_wdata`=32'hDEADBEEF with Pass, then assert `rst` between clock edges → all outputs read 0 before the next edge. They stay 0 while `rst` is high.
- **Pass:** `stall`=6'b000000, `ex_wd`=5'd7, `ex_wreg`=1, `ex_wdata`=32'h0000FF00, `ex_whilo`=1, `ex_hi`=32'h1, `ex_lo`=32'h2 → next edge: `mem_*` equal these values; `hilo_o`=0, `cnt_o`=0.
- **Bubble:** `stall`=6'b001111, `hilo_i`=64'h0000_0001_0000_0002, `cnt_i`=2'b01 → next edge: `mem_wreg`=0, `mem_whilo`=0, `mem_wdata`=0, `hilo_o`=64'h0000_0001_0000_0002, `cnt_o`=2'b01.
- **Hold:** after a Pass loading `mem_wdata`=32'h12345678, apply `stall`=6'b011111 for 3 cycles while `ex_wdata` toggles → `mem_wdata` stays 32'h12345678 for all 3 cycles.
- **Accumulation sequence:** one Bubble with `cnt_i`=2'b01, then Pass with `ex_hi`=32'hA, `ex_lo`=32'hB → `mem_hi`=32'hA, `mem_lo`=32'hB, `cnt_o` returns to 0.
- **Configuration build:** compile without `EX_MEM_HILO_EN` and repeat the Pass and Bubble cases → same values on `mem_wd`, `mem_wreg` and `mem_wdata`.
